// File: rtl/regfile_2r1w_sb.sv
// ============================================================================
// Module      : regfile_2r1w_sb
// Description : 2-read/1-write register file with a per-register busy
//               scoreboard, optional write-to-read forwarding and busy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_2r1w_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] writenum,
  input  logic              write,
  input  logic [ADDR_W-1:0] readnum_a,
  input  logic [ADDR_W-1:0] readnum_b,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  input  logic              claim,
  input  logic [ADDR_W-1:0] claimnum,
  output logic              busy_a,
  output logic              busy_b,
  output logic [ADDR_W:0]   busy_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic [NREGS-1:0]  w_busy_next;
  logic [ADDR_W:0]   r_busy_count;
  logic [ADDR_W:0]   w_busy_count_next;
  logic              w_fwd_en;
  logic              w_fwd_a;
  logic              w_fwd_b;
  logic              w_claim_a;
  logic              w_claim_b;

  // Claim is applied after the write-clear so a same-register claim wins.
  always_comb begin
    w_busy_next = r_busy;
    if (write) w_busy_next[writenum] = 1'b0;
    if (claim) w_busy_next[claimnum] = 1'b1;
  end

  always_comb begin
    w_busy_count_next = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_busy_count_next = w_busy_count_next + {{ADDR_W{1'b0}}, w_busy_next[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      if (write) r_regs[writenum] <= data_in;
      r_busy       <= w_busy_next;
      r_busy_count <= w_busy_count_next;
    end
  end

  // Forwarding is suppressed during reset so every output reads zero at once.
  generate
    if (BYPASS != 0) begin : g_bypass
      assign w_fwd_en = write & ~reset;
    end else begin : g_no_bypass
      assign w_fwd_en = 1'b0;
    end
  endgenerate

  assign w_fwd_a   = w_fwd_en & (writenum == readnum_a);
  assign w_fwd_b   = w_fwd_en & (writenum == readnum_b);
  assign w_claim_a = claim & (claimnum == readnum_a);
  assign w_claim_b = claim & (claimnum == readnum_b);

  assign data_out_a = w_fwd_a ? data_in : r_regs[readnum_a];
  assign data_out_b = w_fwd_b ? data_in : r_regs[readnum_b];
  assign busy_a     = (w_fwd_a & ~w_claim_a) ? 1'b0 : r_busy[readnum_a];
  assign busy_b     = (w_fwd_b & ~w_claim_b) ? 1'b0 : r_busy[readnum_b];
  assign busy_count = r_busy_count;

endmodule

`default_nettype wire

// File: doc/regfile_2r1w_sb.md
REGFILE_2R1W_SB -- requirements
Module: regfile_2r1w_sb

Interface
- Parameters
  - REQ-001: The block SHALL have parameter DATA_W, default 16, giving the register and data width in bits.
  - REQ-002: The block SHALL have parameter ADDR_W, default 3, giving the register-number width; NREGS = 2**ADDR_W.
  - REQ-003: The block SHALL have parameter BYPASS, default 1, which enables write-to-read forwarding when 1.
- Ports
  - REQ-004: clk  input  1  is the single clock; all state updates occur on the rising edge.
  - REQ-005: reset  input  1  is an asynchronous, active-high reset.
  - REQ-006: data_in  input  DATA_W  carries the write data.
  - REQ-007: writenum  input  ADDR_W  selects the write target register.
  - REQ-008: write  input  1  is the write enable.
  - REQ-009: readnum_a, readnum_b  input  ADDR_W each  select the registers for read ports A and B.
  - REQ-010: data_out_a, data_out_b  output  DATA_W each  carry the read data for ports A and B.
  - REQ-011: claim  input  1  requests that scoreboard register claimnum be marked pending.
  - REQ-012: claimnum  input  ADDR_W  selects the register to claim.
  - REQ-013: busy_a, busy_b  output  1 each  give the pending status of the register selected by readnum_a and readnum_b.
  - REQ-014: busy_count  output  ADDR_W+1  gives the number of registers currently pending, as a registered value.

Function
- REQ-015: The block SHALL write data_in into register[writenum] at the rising edge of clk when write=1; no other register SHALL change.
- REQ-016: The read ports SHALL be combinational: data_out_x = register[readnum_x] with zero-cycle latency, and both ports SHALL be usable on the same or different registers in the same cycle.
- REQ-017: When BYPASS=1, write=1 and writenum==readnum_x, data_out_x SHALL equal data_in in that same cycle; when BYPASS=0, it SHALL show the old register value until the next edge.
- REQ-018: The scoreboard SHALL hold one busy bit per register; claim=1 SHALL set busy[claimnum] at the clock edge.
- REQ-019: write=1 SHALL clear busy[writenum] at the clock edge.
- REQ-020: When claim and write occur in the same cycle to the same register, the claim SHALL win: the data is written and busy remains 1.
- REQ-021: Writing a non-busy register SHALL be legal, store the data, and leave busy at 0.
- REQ-022: Claiming an already-busy register SHALL leave its busy bit at 1 with no error indication.
- REQ-023: busy_x SHALL equal busy[readnum_x]; when BYPASS=1, a same-cycle write to readnum_x without a same-register claim SHALL force busy_x to 0.
- REQ-024: busy_count SHALL equal the population count of the busy bits after each edge, ranging from 0 to NREGS without wrap.

Reset
- REQ-025: Asserting reset SHALL immediately clear all registers to 0, all busy bits to 0 and busy_count to 0, independent of clk.
- REQ-026: While reset=1, write and claim SHALL be ignored.
- REQ-027: A write or claim in flight when reset is asserted SHALL be discarded.
- REQ-028: Normal operation SHALL resume at the first rising edge after reset deasserts.

Verification
- REQ-029: Reset, then read all registers on both ports -> every data_out = 0, busy_a = busy_b = 0, busy_count = 0.
- REQ-030: Write 16'hABCD to R5, then read with readnum_a=5 and readnum_b=5 -> both outputs = 16'hABCD and the other registers remain 0.
- REQ-031: With BYPASS=1, write=1, writenum=3, data_in=16'h1234 and readnum_a=3 in the same cycle -> data_out_a = 16'h1234 before the edge; repeat with BYPASS=0 -> the old value before the edge.
- REQ-032: Claim R2 and R6 in consecutive cycles -> busy_count = 2; then write R2 -> busy[2] = 0 and busy_count = 1.
- REQ-033: Claim and write R4 in the same cycle -> R4 is updated, busy[4] = 1 and busy_count increments.
- REQ-034: Claim all 8 registers, then assert reset mid-cycle -> all outputs are 0 immediately, before the next clk edge.
